// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display block.
// Holds the FSM state encoding, the per-digit BCD limits and the
// active-low 7-segment patterns with their decode function.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MAX_ONES = 4'd9;
  localparam logic [3:0] DIGIT_MAX_TENS = 4'd5;

  // Segment order {g,f,e,d,c,b,a}, 0 = segment lit
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Non-decimal nibbles show nothing rather than a hex glyph
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the stopwatch count.
// Ports: clk, rst (sync, active-high), clear (sync zero), inc (count
// enable), max (last value before wrap); value (current digit),
// carry (inc seen while at max, i.e. this digit wraps now).
module bcd_digit_counter
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  input  logic [3:0] max,
  output logic [3:0] value,
  output logic       carry
);

  assign carry = inc && (value == max);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value <= 4'd0;
    end else if (inc) begin
      value <= (value == max) ? 4'd0 : value + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_display.sv
// MM:SS stopwatch with a multiplexed 4-digit 7-segment display.
// Ports: clk, rst (sync, active-high), tick_1hz, start_stop, clear
// (one-cycle pulses); bcd {min_tens,min_ones,sec_tens,sec_ones},
// running, rollover (59:59 -> 00:00 pulse); seg {g..a}, dp, an
// (all active-low, an[0] = sec_ones).
//
// state    | meaning
// ST_IDLE  | stopped at 00:00, waiting for start
// ST_RUN   | counting on tick_1hz
// ST_PAUSE | stopped holding the count; clear returns to IDLE
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        start_stop,
  input  logic        clear,
  output logic [15:0] bcd,
  output logic        running,
  output logic        rollover,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  state_t state, state_next;
  logic   count_en, count_clr, running_next;
  logic   carry_so, carry_st, carry_mo, carry_mt;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_stop) state_next = ST_RUN;
      ST_RUN:   if (start_stop) state_next = ST_PAUSE;
      ST_PAUSE: begin
        // clear outranks start_stop when both arrive together
        if (clear)           state_next = ST_IDLE;
        else if (start_stop) state_next = ST_RUN;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    count_en     = (state == ST_RUN) && tick_1hz;
    count_clr    = (state != ST_RUN) && clear;
    // Loaded from the next state so running lines up with state itself
    running_next = (state_next == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running  <= 1'b0;
      rollover <= 1'b0;
    end else begin
      running  <= running_next;
      rollover <= carry_mt;
    end
  end

  bcd_digit_counter u_sec_ones (
    .clk(clk), .rst(rst), .clear(count_clr), .inc(count_en),
    .max(DIGIT_MAX_ONES), .value(bcd[3:0]), .carry(carry_so)
  );
  bcd_digit_counter u_sec_tens (
    .clk(clk), .rst(rst), .clear(count_clr), .inc(carry_so),
    .max(DIGIT_MAX_TENS), .value(bcd[7:4]), .carry(carry_st)
  );
  bcd_digit_counter u_min_ones (
    .clk(clk), .rst(rst), .clear(count_clr), .inc(carry_st),
    .max(DIGIT_MAX_ONES), .value(bcd[11:8]), .carry(carry_mo)
  );
  bcd_digit_counter u_min_tens (
    .clk(clk), .rst(rst), .clear(count_clr), .inc(carry_mo),
    .max(DIGIT_MAX_TENS), .value(bcd[15:12]), .carry(carry_mt)
  );

  logic [CW-1:0] scan_cnt;
  logic [1:0]    digit_idx, digit_idx_next;
  logic [3:0]    nibble_next;

  always_comb begin
    digit_idx_next = (scan_cnt == SCAN_LAST) ? digit_idx + 2'd1 : digit_idx;
    case (digit_idx_next)
      2'd0:    nibble_next = bcd[3:0];
      2'd1:    nibble_next = bcd[7:4];
      2'd2:    nibble_next = bcd[11:8];
      default: nibble_next = bcd[15:12];
    endcase
  end

  // an, seg and dp all come from the upcoming index so they switch together
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
      an        <= 4'b1110;
      seg       <= SEG_0;
      dp        <= 1'b1;
    end else begin
      scan_cnt  <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + CW'(1);
      digit_idx <= digit_idx_next;
      an        <= ~(4'b0001 << digit_idx_next);
      seg       <= seg_decode(nibble_next);
      dp        <= (digit_idx_next != 2'd2);
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display (SCAN_DIV = 4).
module tb_stopwatch_display;

  logic        clk = 1'b0;
  logic        rst, tick_1hz, start_stop, clear;
  logic [15:0] bcd;
  logic        running, rollover, dp;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_pass  = 0;
  int n_total = 0;

  stopwatch_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .start_stop(start_stop),
    .clear(clear), .bcd(bcd), .running(running), .rollover(rollover),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ss;
    logic        clr;
    logic        tk;
    logic [15:0] exp_bcd;
    logic        exp_run;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cycle(input logic ss, input logic clr, input logic tk);
    @(negedge clk);
    start_stop = ss;
    clear      = clr;
    tick_1hz   = tk;
    @(posedge clk);
    #1;
  endtask

  logic roll_seen;

  task automatic ticks(input int n);
    roll_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      if (rollover) roll_seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start_stop = 1'b0; clear = 1'b0; tick_1hz = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bcd"}, 32'(bcd), 32'h0000);
    chk({tag, "_running"}, 32'(running), 32'd0);
    chk({tag, "_rollover"}, 32'(rollover), 32'd0);
    chk({tag, "_an"}, 32'(an), 32'b1110);
    chk({tag, "_seg"}, 32'(seg), 32'b1000000);
    chk({tag, "_dp"}, 32'(dp), 32'd1);
  endtask

  logic [3:0] exp_an[4];
  logic [6:0] exp_seg[4];
  logic       exp_dp[4];
  logic [3:0] prev_an;
  bit         synced;

  initial begin
    rst = 1'b1; start_stop = 1'b0; clear = 1'b0; tick_1hz = 1'b0;

    // ss, clr, tick, expected bcd after the edge, expected running
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0002, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0002, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'h0003, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 16'h0004, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0004, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 16'h0004, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 16'h0005, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 16'h0005, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b1};

    exp_an[0] = 4'b1110; exp_seg[0] = 7'b0010010; exp_dp[0] = 1'b1;
    exp_an[1] = 4'b1101; exp_seg[1] = 7'b0110000; exp_dp[1] = 1'b1;
    exp_an[2] = 4'b1011; exp_seg[2] = 7'b0100100; exp_dp[2] = 1'b0;
    exp_an[3] = 4'b0111; exp_seg[3] = 7'b1111001; exp_dp[3] = 1'b1;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk_reset_outputs("reset");
    @(negedge clk); rst = 1'b0;

    // FSM / counting vector table
    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].ss, vecs[i].clr, vecs[i].tk);
      chk($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(vecs[i].exp_bcd));
      chk($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].exp_run));
      chk($sformatf("vec%0d_rollover", i), 32'(rollover), 32'd0);
    end

    // Start then five ticks
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    ticks(5);
    chk("five_ticks_bcd", 32'(bcd), 32'h0005);
    chk("five_ticks_running", 32'(running), 32'd1);

    // Seconds and minutes carries
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    ticks(9);
    chk("nine_ticks_bcd", 32'(bcd), 32'h0009);
    ticks(1);
    chk("ten_ticks_bcd", 32'(bcd), 32'h0010);
    ticks(49);
    chk("59_ticks_bcd", 32'(bcd), 32'h0059);
    ticks(1);
    chk("60_ticks_bcd", 32'(bcd), 32'h0100);

    // Full wrap at 59:59
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    ticks(3599);
    chk("3599_ticks_bcd", 32'(bcd), 32'h5959);
    chk("no_early_rollover", 32'(roll_seen), 32'd0);
    ticks(1);
    chk("wrap_bcd", 32'(bcd), 32'h0000);
    chk("wrap_rollover", 32'(rollover), 32'd1);
    chk("wrap_running", 32'(running), 32'd1);
    cycle(1'b0, 1'b0, 1'b0);
    chk("rollover_one_cycle", 32'(rollover), 32'd0);
    chk("post_wrap_bcd", 32'(bcd), 32'h0000);

    // Pause freezes count, clear+start_stop from PAUSE goes IDLE
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    ticks(3);
    cycle(1'b1, 1'b0, 1'b0);
    ticks(4);
    chk("paused_bcd", 32'(bcd), 32'h0003);
    chk("paused_running", 32'(running), 32'd0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("clear_wins_bcd", 32'(bcd), 32'h0000);
    chk("clear_wins_running", 32'(running), 32'd0);
    ticks(2);
    chk("idle_after_clear_bcd", 32'(bcd), 32'h0000);

    // Display scan at 12:35
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    ticks(755);
    cycle(1'b1, 1'b0, 1'b0);
    chk("scan_setup_bcd", 32'(bcd), 32'h1235);
    synced  = 1'b0;
    prev_an = an;
    for (int i = 0; i < 20 && !synced; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (an == 4'b1110 && prev_an != 4'b1110) synced = 1'b1;
      prev_an = an;
    end
    chk("scan_sync", 32'(synced), 32'd1);
    if (synced) begin
      for (int c = 0; c < 16; c++) begin
        chk($sformatf("scan_an_c%0d", c), 32'(an), 32'(exp_an[c / 4]));
        chk($sformatf("scan_seg_c%0d", c), 32'(seg), 32'(exp_seg[c / 4]));
        chk($sformatf("scan_dp_c%0d", c), 32'(dp), 32'(exp_dp[c / 4]));
        cycle(1'b0, 1'b0, 1'b0);
      end
    end

    // Reset in the middle of RUN, with other inputs active
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    ticks(42);
    chk("pre_reset_bcd", 32'(bcd), 32'h0042);
    chk("pre_reset_running", 32'(running), 32'd1);
    @(negedge clk);
    rst = 1'b1; start_stop = 1'b1; clear = 1'b0; tick_1hz = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("midrun_reset");
    @(negedge clk);
    rst = 1'b0; start_stop = 1'b0; tick_1hz = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, the clk cycles per display digit (1 kHz digit refresh at 100 MHz).
REQ-002 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port tick_1hz  input  1  one-cycle enable pulse from the 1 Hz divider stage.
REQ-005 SHALL have port start_stop  input  1  one-cycle debounced pulse that toggles run/pause.
REQ-006 SHALL have port clear  input  1  one-cycle debounced pulse that zeroes the count.
REQ-007 SHALL have port bcd  output  16  count {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
REQ-008 SHALL have port running  output  1  high while in RUN.
REQ-009 SHALL have port rollover  output  1  one-cycle pulse on the 59:59 -> 00:00 wrap.
REQ-010 SHALL have port seg  output  7  active-low cathodes {g,f,e,d,c,b,a}.
REQ-011 SHALL have port dp  output  1  active-low decimal point.
REQ-012 SHALL have port an  output  4  active-low one-hot digit anodes; an[0] = sec_ones.

Function
REQ-013 SHALL implement FSM IDLE, RUN, PAUSE.
REQ-014 IDLE: start_stop -> RUN; clear has no effect beyond holding 00:00.
REQ-015 RUN: start_stop -> PAUSE; clear is ignored.
REQ-016 PAUSE: start_stop -> RUN; clear -> IDLE with bcd = 0.
REQ-017 PAUSE with clear and start_stop in the same cycle SHALL go to IDLE (clear wins).
REQ-018 The count SHALL increment on the clk edge sampling tick_1hz high only when the current state is RUN, giving a 1-cycle latency.
REQ-019 A tick coinciding with start_stop in RUN SHALL still be counted; a tick coinciding with start_stop in PAUSE or IDLE SHALL NOT be counted.
REQ-020 Digit ranges SHALL be sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0-5, each carrying into the next digit on wrap.
REQ-021 An increment from 59:59 SHALL produce 00:00, assert rollover for exactly that one cycle, and keep the state RUN.
REQ-022 running SHALL be a registered decode of state == RUN.
REQ-023 The scan counter SHALL count 0..SCAN_DIV-1; at terminal count it SHALL wrap to 0 and advance the digit index 0->1->2->3->0.
REQ-024 an SHALL equal ~(1 << index); seg SHALL be the active-low hex-to-7-seg decode of the indexed bcd nibble, registered with an so both change on the same edge.
REQ-025 dp SHALL be 0 (lit) when index == 2 (minutes/seconds separator) and 1 otherwise.
REQ-026 Any BCD value above 9 reaching the decoder SHALL display blank (7'b1111111).

Reset
REQ-027 rst SHALL set state = IDLE, bcd = 16'h0000, running = 0, rollover = 0, scan counter = 0, index = 0.
REQ-028 rst SHALL set an = 4'b1110, seg = 7'b1000000 ("0") and dp = 1.
REQ-029 rst SHALL take priority over all other inputs, including in the middle of RUN.

Structure
REQ-030 Package stopwatch_pkg SHALL hold the FSM state encoding, the digit limits (9, 5) and the 7-seg patterns for 0-9 plus blank.
REQ-031 Sub-module bcd_digit_counter (inputs: inc, max; outputs: value, carry) SHALL be instantiated four times in a ripple-carry chain.

Verification
REQ-032 Reset, start_stop, 5 ticks -> bcd = 16'h0005, running = 1.
REQ-033 In RUN, 10 ticks from 00:00 -> bcd = 16'h0010; 60 ticks -> 16'h0100.
REQ-034 In RUN, 3599 ticks then 1 tick -> bcd = 16'h0000, rollover high for exactly 1 cycle, running = 1.
REQ-035 start_stop, 3 ticks, start_stop, 4 ticks -> bcd = 16'h0003; then clear and start_stop in the same cycle -> IDLE, bcd = 0, running = 0.
REQ-036 SCAN_DIV = 4, bcd = 16'h1235 -> an steps 1110, 1101, 1011, 0111 every 4 cycles, with seg = 0010010, 0110000, 0100100, 1111001 respectively and dp = 0 only at 1011.
REQ-037 rst asserted mid-RUN at bcd = 16'h0042 -> next cycle all outputs at their REQ-027/REQ-028 values.
